// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle control unit:
// FSM states, instruction classes, opcodes, ALU function codes and status bits.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_ADD,
    CLS_SUB,
    CLS_AND,
    CLS_ORR,
    CLS_ADDI,
    CLS_SUBI,
    CLS_LDUR,
    CLS_STUR,
    CLS_CBZ,
    CLS_B,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  // SUB is ADD with the B operand inverted (bit 0) and carry-in set.
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  localparam int STATUS_Z = 0;
  localparam int STATUS_N = 1;
  localparam int STATUS_C = 2;
  localparam int STATUS_V = 3;

  localparam logic [4:0] XZR = 5'd31;

  // Word offset to byte offset; the low 30 bits of a sign-extended immediate suffice mod 2^32.
  function automatic logic [31:0] branch_offset(input logic [63:0] imm);
    return {imm[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/legv8_decoder.sv
// Combinational instruction decoder: classifies the IR and extracts register
// fields plus the zero/sign-extended immediate for that class.
module legv8_decoder
  import legv8_ctrl_pkg::*;
(
  input  logic [31:0]  ir,
  output instr_class_t cls,
  output logic [4:0]   rd,
  output logic [4:0]   rn,
  output logic [4:0]   rm,
  output logic [4:0]   rt,
  output logic [63:0]  imm
);

  assign rd = ir[4:0];
  assign rt = ir[4:0];
  assign rn = ir[9:5];
  assign rm = ir[20:16];

  always_comb begin
    cls = CLS_ILLEGAL;
    if      (ir[31:21] == OP_ADD)  cls = CLS_ADD;
    else if (ir[31:21] == OP_SUB)  cls = CLS_SUB;
    else if (ir[31:21] == OP_AND)  cls = CLS_AND;
    else if (ir[31:21] == OP_ORR)  cls = CLS_ORR;
    else if (ir[31:21] == OP_LDUR) cls = CLS_LDUR;
    else if (ir[31:21] == OP_STUR) cls = CLS_STUR;
    else if (ir[31:22] == OP_ADDI) cls = CLS_ADDI;
    else if (ir[31:22] == OP_SUBI) cls = CLS_SUBI;
    else if (ir[31:24] == OP_CBZ)  cls = CLS_CBZ;
    else if (ir[31:26] == OP_B)    cls = CLS_B;
  end

  always_comb begin
    imm = '0;
    case (cls)
      CLS_ADDI, CLS_SUBI: imm = {52'd0, ir[21:10]};
      CLS_LDUR, CLS_STUR: imm = {{55{ir[20]}}, ir[20:12]};
      CLS_CBZ:            imm = {{45{ir[23]}}, ir[23:5]};
      CLS_B:              imm = {{38{ir[25]}}, ir[25:0]};
      default:            imm = '0;
    endcase
  end

endmodule

// File: rtl/legv8_multicycle_control.sv
// Multi-cycle LEGv8 control FSM: owns PC and IR, sequences FETCH/DECODE/EXEC/MEM,
// and decodes datapath selects/enables from the current state and IR.
module legv8_multicycle_control
  import legv8_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [3:0]  status,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] pc,
  output logic        EN_PC,
  output logic [4:0]  DA,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic        W,
  output logic [4:0]  FS,
  output logic        C0,
  output logic        Bsel,
  output logic [63:0] constant,
  output logic        EN_ALU,
  output logic        EN_B,
  output logic        EN_ADDR_ALU,
  output logic        halted
);

  state_t       state_reg, state_next;
  logic [31:0]  pc_reg, pc_next, pc_seq;
  logic [31:0]  ir_reg;
  instr_class_t cls;
  logic [4:0]   rd, rn, rm, rt;
  logic [63:0]  imm;
  logic         unused_status;

  assign unused_status = ^status[3:1];
  assign pc            = pc_reg;
  assign pc_seq        = pc_reg + 32'd4;

  legv8_decoder u_decoder (
    .ir  (ir_reg),
    .cls (cls),
    .rd  (rd),
    .rn  (rn),
    .rm  (rm),
    .rt  (rt),
    .imm (imm)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_FETCH;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (state_reg == ST_FETCH && mem_ready) ir_reg <= instr;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      ST_FETCH:  if (mem_ready) state_next = ST_DECODE;
      ST_DECODE: state_next = (cls == CLS_ILLEGAL) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        case (cls)
          CLS_LDUR, CLS_STUR: state_next = ST_MEM;
          CLS_CBZ: begin
            state_next = ST_FETCH;
            pc_next    = status[STATUS_Z] ? pc_reg + branch_offset(imm) : pc_seq;
          end
          CLS_B: begin
            state_next = ST_FETCH;
            pc_next    = pc_reg + branch_offset(imm);
          end
          default: begin
            state_next = ST_FETCH;
            pc_next    = pc_seq;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_next = ST_FETCH;
          pc_next    = pc_seq;
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  // Outputs are held idle while reset is asserted so strobes drop without waiting for a clock.
  always_comb begin
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    EN_PC       = 1'b0;
    DA          = '0;
    SA          = '0;
    SB          = '0;
    W           = 1'b0;
    FS          = '0;
    C0          = 1'b0;
    Bsel        = 1'b0;
    constant    = '0;
    EN_ALU      = 1'b0;
    EN_B        = 1'b0;
    EN_ADDR_ALU = 1'b0;
    halted      = 1'b0;
    if (reset) begin
      case (state_reg)
        ST_FETCH: begin
          EN_PC  = 1'b1;
          mem_rd = 1'b1;
        end
        ST_EXEC: begin
          case (cls)
            CLS_ADD, CLS_SUB, CLS_AND, CLS_ORR, CLS_ADDI, CLS_SUBI: begin
              SA     = rn;
              SB     = rm;
              DA     = rd;
              EN_ALU = 1'b1;
              W      = (rd != XZR);
              case (cls)
                CLS_SUB, CLS_SUBI: begin
                  FS = FS_SUB;
                  C0 = 1'b1;
                end
                CLS_AND: FS = FS_AND;
                CLS_ORR: FS = FS_OR;
                default: FS = FS_ADD;
              endcase
              if (cls == CLS_ADDI || cls == CLS_SUBI) begin
                Bsel     = 1'b1;
                constant = imm;
              end
            end
            CLS_LDUR, CLS_STUR: begin
              SA          = rn;
              Bsel        = 1'b1;
              constant    = imm;
              FS          = FS_ADD;
              EN_ADDR_ALU = 1'b1;
            end
            CLS_CBZ: begin
              SA   = rt;
              Bsel = 1'b1;
              FS   = FS_ADD;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          SA          = rn;
          Bsel        = 1'b1;
          constant    = imm;
          FS          = FS_ADD;
          EN_ADDR_ALU = 1'b1;
          if (cls == CLS_LDUR) begin
            mem_rd = 1'b1;
            DA     = rt;
            W      = mem_ready && (rt != XZR);
          end else begin
            SB     = rt;
            EN_B   = 1'b1;
            mem_wr = 1'b1;
          end
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
